// File: rtl/multicycle_cpu_if.sv
// Memory-side bus of the multicycle CPU: combinational instruction fetch
// plus a request/ready data port.
interface multicycle_cpu_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned PC_W   = 16
);
    logic [PC_W-1:0]   imem_addr;
    logic [31:0]       imem_rdata;
    logic              dmem_req;
    logic              dmem_we;
    logic [PC_W-1:0]   dmem_addr;
    logic [DATA_W-1:0] dmem_wdata;
    logic [DATA_W-1:0] dmem_rdata;
    logic              dmem_ready;

    modport master (
        output imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  imem_rdata, dmem_rdata, dmem_ready
    );

    modport slave (
        input  imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output imem_rdata, dmem_rdata, dmem_ready
    );
endinterface

// File: rtl/multicycle_cpu.sv
// Non-pipelined MIPS-subset core: FETCH/DECODE/EXEC/MEM/WB/HALT, one
// instruction in flight, data accesses stall on dmem_ready.
module multicycle_cpu #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned PC_W     = 16,
    parameter int unsigned NREGS    = 32,
    parameter int unsigned RESET_PC = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    multicycle_cpu_if.master     mem,
    output logic [PC_W-1:0]      pc,
    output logic                 retire,
    output logic                 halted,
    output logic                 illegal
);
    localparam int unsigned RIDX_W = (NREGS > 1) ? $clog2(NREGS) : 1;

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;

    localparam logic [5:0] OP_R    = 6'd0;
    localparam logic [5:0] OP_ADDI = 6'd8;
    localparam logic [5:0] OP_LW   = 6'd35;
    localparam logic [5:0] OP_SW   = 6'd43;
    localparam logic [5:0] OP_BEQ  = 6'd4;
    localparam logic [5:0] OP_HALT = 6'd63;
    localparam logic [5:0] FN_ADD  = 6'd32;
    localparam logic [5:0] FN_SUB  = 6'd34;
    localparam logic [5:0] FN_AND  = 6'd36;
    localparam logic [5:0] FN_OR   = 6'd37;
    localparam logic [5:0] FN_SLT  = 6'd42;

    logic [2:0]        r_state, w_state_nxt;
    logic [31:0]       r_ir;
    logic [DATA_W-1:0] r_a, r_b, r_imm, r_res;
    logic [RIDX_W-1:0] r_dst;
    logic [PC_W-1:0]   r_pc, r_dmem_addr;
    logic [DATA_W-1:0] r_dmem_wdata;
    logic              r_dmem_req, r_dmem_we, r_retire, r_halted, r_illegal;
    logic [DATA_W-1:0] r_regs [NREGS];

    logic [5:0]        w_op, w_funct;
    logic [RIDX_W-1:0] w_rs, w_rt, w_rd;
    logic [DATA_W-1:0] w_alu;
    logic [PC_W-1:0]   w_pc_inc, w_pc_br;
    logic              w_is_r, w_is_addi, w_is_lw, w_is_sw, w_is_beq, w_is_halt, w_illegal;
    logic              w_unused;

    assign w_op     = r_ir[31:26];
    assign w_funct  = r_ir[5:0];
    assign w_rs     = r_ir[21 +: RIDX_W];
    assign w_rt     = r_ir[16 +: RIDX_W];
    assign w_rd     = r_ir[11 +: RIDX_W];
    assign w_pc_inc = r_pc + PC_W'(1);
    assign w_pc_br  = r_pc + PC_W'(1) + PC_W'($signed(r_ir[15:0]));
    assign w_unused = ^r_ir[10:6];

    // Instruction class and ALU result, valid while r_ir holds the instruction
    always_comb begin
        w_is_r    = 1'b0;
        w_is_addi = 1'b0;
        w_is_lw   = 1'b0;
        w_is_sw   = 1'b0;
        w_is_beq  = 1'b0;
        w_is_halt = 1'b0;
        w_alu     = '0;
        case (w_op)
            OP_R: begin
                w_is_r = 1'b1;
                case (w_funct)
                    FN_ADD:  w_alu = r_a + r_b;
                    FN_SUB:  w_alu = r_a - r_b;
                    FN_AND:  w_alu = r_a & r_b;
                    FN_OR:   w_alu = r_a | r_b;
                    FN_SLT:  w_alu = DATA_W'($signed(r_a) < $signed(r_b));
                    default: w_is_r = 1'b0;
                endcase
            end
            OP_ADDI: begin w_is_addi = 1'b1; w_alu = r_a + r_imm; end
            OP_LW:   begin w_is_lw   = 1'b1; w_alu = r_a + r_imm; end
            OP_SW:   begin w_is_sw   = 1'b1; w_alu = r_a + r_imm; end
            OP_BEQ:  w_is_beq  = 1'b1;
            OP_HALT: w_is_halt = 1'b1;
            default: ;
        endcase
        w_illegal = ~(w_is_r | w_is_addi | w_is_lw | w_is_sw | w_is_beq | w_is_halt);
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_FETCH;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_FETCH:  w_state_nxt = S_DECODE;
            S_DECODE: w_state_nxt = S_EXEC;
            S_EXEC: begin
                if (w_is_halt || w_illegal)  w_state_nxt = S_HALT;
                else if (w_is_beq)           w_state_nxt = S_FETCH;
                else if (w_is_lw || w_is_sw) w_state_nxt = S_MEM;
                else                         w_state_nxt = S_WB;
            end
            S_MEM:    if (mem.dmem_ready) w_state_nxt = r_dmem_we ? S_FETCH : S_WB;
            S_WB:     w_state_nxt = S_FETCH;
            S_HALT:   w_state_nxt = S_HALT;
            default:  w_state_nxt = S_FETCH;
        endcase
    end

    // Datapath, register file and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ir         <= '0;
            r_a          <= '0;
            r_b          <= '0;
            r_imm        <= '0;
            r_res        <= '0;
            r_dst        <= '0;
            r_pc         <= PC_W'(RESET_PC);
            r_dmem_req   <= 1'b0;
            r_dmem_we    <= 1'b0;
            r_dmem_addr  <= '0;
            r_dmem_wdata <= '0;
            r_retire     <= 1'b0;
            r_halted     <= 1'b0;
            r_illegal    <= 1'b0;
            for (int i = 0; i < int'(NREGS); i++) r_regs[i] <= '0;
        end else begin
            r_retire <= 1'b0;
            case (r_state)
                S_FETCH: r_ir <= mem.imem_rdata;
                S_DECODE: begin
                    r_a   <= r_regs[w_rs];
                    r_b   <= r_regs[w_rt];
                    r_imm <= DATA_W'($signed(r_ir[15:0]));
                end
                S_EXEC: begin
                    r_res <= w_alu;
                    r_dst <= w_is_r ? w_rd : w_rt;
                    if (w_is_beq) begin
                        r_pc     <= (r_a == r_b) ? w_pc_br : w_pc_inc;
                        r_retire <= 1'b1;
                    end
                    if (w_is_lw || w_is_sw) begin
                        r_dmem_req   <= 1'b1;
                        r_dmem_we    <= w_is_sw;
                        r_dmem_addr  <= PC_W'(w_alu);
                        r_dmem_wdata <= r_b;
                    end
                    if (w_is_halt || w_illegal) r_halted  <= 1'b1;
                    if (w_illegal)              r_illegal <= 1'b1;
                end
                S_MEM: begin
                    if (mem.dmem_ready) begin
                        r_dmem_req <= 1'b0;
                        if (r_dmem_we) begin
                            r_retire <= 1'b1;
                            r_pc     <= w_pc_inc;
                        end else begin
                            r_res <= mem.dmem_rdata;
                        end
                    end
                end
                S_WB: begin
                    if (r_dst != '0) r_regs[r_dst] <= r_res;
                    r_retire <= 1'b1;
                    r_pc     <= w_pc_inc;
                end
                default: ;
            endcase
        end
    end

    assign mem.imem_addr  = r_pc;
    assign mem.dmem_req   = r_dmem_req;
    assign mem.dmem_we    = r_dmem_we;
    assign mem.dmem_addr  = r_dmem_addr;
    assign mem.dmem_wdata = r_dmem_wdata;
    assign pc             = r_pc;
    assign retire         = r_retire;
    assign halted         = r_halted;
    assign illegal        = r_illegal;
endmodule

// File: doc/multicycle_cpu.md
MULTICYCLE_CPU -- requirements
Module: multicycle_cpu

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning datapath/register width (legal 16..64).
REQ-002 SHALL have parameter PC_W, default 16, meaning word-address width of PC and memory addresses.
REQ-003 SHALL have parameter NREGS, default 32, meaning register-file entries (power of 2, max 32).
REQ-004 SHALL have parameter RESET_PC, default 0, meaning PC value loaded at reset.
REQ-005 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-007 SHALL have port imem_addr  output  PC_W  instruction word address (equals pc).
REQ-008 SHALL have port imem_rdata  input  32  instruction word, combinational from imem_addr.
REQ-009 SHALL have port dmem_req  output  1  data-memory request valid.
REQ-010 SHALL have port dmem_we  output  1  1 = store, 0 = load; valid only with dmem_req.
REQ-011 SHALL have port dmem_addr  output  PC_W  data word address (ALU result, low PC_W bits).
REQ-012 SHALL have port dmem_wdata  output  DATA_W  store data (rt value).
REQ-013 SHALL have port dmem_rdata  input  DATA_W  load data, sampled in the cycle dmem_ready=1.
REQ-014 SHALL have port dmem_ready  input  1  memory completes the request this cycle.
REQ-015 SHALL have port pc  output  PC_W  current program counter.
REQ-016 SHALL have port retire  output  1  one-cycle pulse when an instruction completes.
REQ-017 SHALL have port halted  output  1  core stopped (HALT opcode or illegal opcode).
REQ-018 SHALL have port illegal  output  1  sticky: halt caused by unknown opcode/funct.

Function
REQ-019 SHALL decode op[31:26], rs[25:21], rt[20:16], rd[15:11], funct[5:0], imm[15:0]; register indices use low log2(NREGS) bits.
REQ-020 SHALL support R-type (op 0): funct 32 add, 34 sub, 36 and, 37 or, 42 slt (signed), rd <- result.
REQ-021 SHALL support addi (op 8), lw (op 35), sw (op 43), beq (op 4), halt (op 63); any other op/funct SHALL halt with illegal=1.
REQ-022 SHALL sign-extend imm to DATA_W; arithmetic wraps modulo 2^DATA_W, no overflow trap.
REQ-023 SHALL keep register 0 reading zero; writes to it discarded.
REQ-024 SHALL use FSM states FETCH, DECODE, EXEC, MEM, WB, HALT; FETCH->DECODE->EXEC always.
REQ-025 FETCH SHALL latch imem_rdata into instruction register; DECODE SHALL latch rs/rt values and sign-extended imm.
REQ-026 EXEC: R/addi -> WB; lw/sw -> MEM; beq -> FETCH with retire; halt/illegal -> HALT.
REQ-027 beq SHALL set pc <- pc+1+imm (mod 2^PC_W) if rs==rt, else pc+1; all others pc <- pc+1 on retire.
REQ-028 MEM SHALL hold dmem_req=1 with stable dmem_we/addr/wdata until dmem_ready=1; no timeout.
REQ-029 lw: on dmem_ready, capture dmem_rdata, go WB; sw: on dmem_ready, retire, go FETCH.
REQ-030 WB SHALL write the destination register, pulse retire, go FETCH.
REQ-031 Latency: beq 3 cycles, R/addi 4, sw 4+W, lw 5+W (W = cycles waited for dmem_ready beyond the first MEM cycle).
REQ-032 HALT SHALL be terminal until rst; halted=1, dmem_req=0, pc frozen at the halting instruction, retire not pulsed.
REQ-033 dmem_req SHALL be 1 only in MEM; register writes occur only in WB.
REQ-034 Register write and read of same register SHALL not conflict (reads happen only in DECODE).

Reset
REQ-035 rst=1 at clock edge SHALL set state FETCH, pc=RESET_PC, retire=0, halted=0, illegal=0, dmem_req=0; registers cleared to zero.
REQ-036 rst asserted mid-MEM SHALL drop dmem_req on the next cycle; the pending access is abandoned and no register write occurs.
REQ-037 rst SHALL take priority over every other event including dmem_ready in the same cycle.

Verification
REQ-038 addi r1,r0,5; addi r2,r0,7; add r3,r1,r2 -> r3=12, retire every 4 cycles, pc=3.
REQ-039 sub r4,r1,r2 (5-7), DATA_W=16 -> r4=0xFFFE; slt r5,r4,r1 -> r5=1.
REQ-040 sw r3,4(r0) with dmem_ready delayed 3 cycles -> dmem_req held 4 cycles, addr 4, wdata 12; lw r6,4(r0) -> r6=12.
REQ-041 beq r1,r1,-1 taken -> pc unchanged, 3-cycle loop; beq r1,r2,+2 not taken -> pc+1.
REQ-042 opcode 0x3F -> halted=1, illegal=0, pc frozen; opcode 0x11 -> halted=1, illegal=1.
REQ-043 rst pulsed during lw MEM wait -> next cycle dmem_req=0, pc=RESET_PC, destination register unchanged (0).
